// File: rtl/rom_dump_streamer.sv
// rom_dump_streamer: walks every ROM address, waits a settle time per address, samples the chip
// data lines and sends each word as an 8N1 UART byte, followed by a mod-256 checksum byte.
//
// Ports:
//   clk           board clock, rising edge
//   reset_n       asynchronous active-low reset
//   start         level input; a sampled rising edge in idle/done starts a dump
//   chip_data_in  chip data lines (zero-extended to 8 bits)
//   address_line  address driven to the chip
//   chip_enable   high while a dump is in progress
//   busy          dump in progress
//   done          last dump completed (cleared by the next accepted start or reset)
//   checksum      running mod-256 sum of the data bytes of the current/last dump
//   uart_tx       serial output, idle high
//
// Timing: busy rises on the clock edge that samples the start edge. The first start bit begins
// SETTLE_CYCLES cycles later, each address takes SETTLE_CYCLES + 10*CLKS_PER_BIT cycles, and the
// checksum frame follows the last stop bit directly. done rises exactly
// 2^ADDRESS_WIDTH*(SETTLE_CYCLES+10*CLKS_PER_BIT) + 10*CLKS_PER_BIT cycles after busy rises, so
// the constant FSM overhead is the single start-registration cycle before busy.
module rom_dump_streamer #(
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SETTLE_CYCLES = 50,
  parameter int unsigned CLKS_PER_BIT  = 434
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    chip_data_in,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic                     chip_enable,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               checksum,
  output logic                     uart_tx
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned BaudW   = $clog2(CLKS_PER_BIT);
  localparam logic [SettleW-1:0]       SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [BaudW-1:0]         BaudLast   = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [ADDRESS_WIDTH-1:0] AddrMax    = '1;

  typedef enum logic [2:0] {StIdle, StSettle, StTxByte, StTxSum, StDone} state_e;

  state_e                   state_q, state_d;
  logic                     start_q;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               sum_q, sum_d;
  logic [7:0]               byte_q, byte_d;
  logic [SettleW-1:0]       settle_q, settle_d;
  logic [BaudW-1:0]         baud_q, baud_d;
  // 0 = start bit, 1..8 = data bits, 9 = stop bit
  logic [3:0]               bit_q, bit_d;
  logic                     tx_q, tx_d;
  logic [7:0]               data_ext;
  logic                     start_edge;

  always_comb begin
    data_ext = '0;
    data_ext[DATA_WIDTH-1:0] = chip_data_in;
  end

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sum_d    = sum_q;
    byte_d   = byte_q;
    settle_d = settle_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_edge) begin
          state_d  = StSettle;
          addr_d   = '0;
          sum_d    = '0;
          settle_d = '0;
        end
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          // Sample only here; the start bit goes out on the next cycle.
          byte_d  = data_ext;
          sum_d   = sum_q + data_ext;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          state_d = StTxByte;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StTxByte, StTxSum: begin
        if (baud_q == BaudLast) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            if (state_q == StTxSum) begin
              state_d = StDone;
            end else if (addr_q == AddrMax) begin
              // Checksum frame starts right after the last stop bit.
              byte_d  = sum_q;
              tx_d    = 1'b0;
              bit_d   = '0;
              state_d = StTxSum;
            end else begin
              addr_d   = addr_q + 1'b1;
              settle_d = '0;
              state_d  = StSettle;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = (bit_q == 4'd8) ? 1'b1 : byte_q[bit_q[2:0]];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      addr_q   <= '0;
      sum_q    <= '0;
      byte_q   <= '0;
      settle_q <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      addr_q   <= addr_d;
      sum_q    <= sum_d;
      byte_q   <= byte_d;
      settle_q <= settle_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
    end
  end

  assign busy         = (state_q == StSettle) || (state_q == StTxByte) || (state_q == StTxSum);
  assign chip_enable  = busy;
  assign done         = (state_q == StDone);
  assign address_line = addr_q;
  assign checksum     = sum_q;
  assign uart_tx      = tx_q;

endmodule

// File: tb/tb_rom_dump_streamer.sv
// Bench for rom_dump_streamer: two instances (8-bit and 4-bit data), a ROM model per instance
// that corrupts its data while the UART line is low, and a cycle-sampled UART receiver.
module tb_rom_dump_streamer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // 8-bit instance
  logic             start8 = 1'b0;
  logic [7:0]       data8;
  logic [1:0]       addr8;
  logic             ce8, busy8, done8, tx8;
  logic [7:0]       sum8;
  logic [3:0][7:0]  rom8;

  // 4-bit instance
  logic             start4 = 1'b0;
  logic [3:0]       data4;
  logic [1:0]       addr4;
  logic             ce4, busy4, done4, tx4;
  logic [7:0]       sum4;
  logic [3:0][3:0]  rom4;

  bit glitch = 1'b1;

  // Data is only valid while the UART line is high; start and zero bits drive inverted data.
  always_comb begin
    data8 = (glitch && tx8 == 1'b0) ? ~rom8[addr8] : rom8[addr8];
    data4 = (glitch && tx4 == 1'b0) ? ~rom4[addr4] : rom4[addr4];
  end

  rom_dump_streamer #(
    .ADDRESS_WIDTH(2), .DATA_WIDTH(8), .SETTLE_CYCLES(3), .CLKS_PER_BIT(4)
  ) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .chip_data_in(data8),
    .address_line(addr8), .chip_enable(ce8), .busy(busy8), .done(done8),
    .checksum(sum8), .uart_tx(tx8)
  );

  rom_dump_streamer #(
    .ADDRESS_WIDTH(2), .DATA_WIDTH(4), .SETTLE_CYCLES(3), .CLKS_PER_BIT(4)
  ) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .chip_data_in(data4),
    .address_line(addr4), .chip_enable(ce4), .busy(busy4), .done(done4),
    .checksum(sum4), .uart_tx(tx4)
  );

  typedef struct {
    logic [3:0][7:0] rom;
    logic [4:0][7:0] exp;
    bit              narrow;
    string           name;
  } vec_t;

  vec_t vecs[4];

  function automatic logic get_tx(input bit sel);
    return sel ? tx4 : tx8;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy4 : busy8;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? done4 : done8;
  endfunction
  function automatic logic get_ce(input bit sel);
    return sel ? ce4 : ce8;
  endfunction
  function automatic logic [1:0] get_addr(input bit sel);
    return sel ? addr4 : addr8;
  endfunction
  function automatic logic [7:0] get_sum(input bit sel);
    return sel ? sum4 : sum8;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start4 = v;
    else     start8 = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Waits for a start bit, then samples mid-bit. Returns at the stop-bit sample point,
  // 38 cycles after the falling edge was first seen.
  task automatic rx_frame(input bit sel, output logic [7:0] b, output int t_fall,
                          output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    b = '0;
    t_fall = 0;
    while (get_tx(sel) !== 1'b0) begin
      if (n >= 400) begin
        ok = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
    end
    t_fall = cyc;
    repeat (2) @(negedge clk);
    if (get_tx(sel) !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = get_tx(sel);
    end
    repeat (4) @(negedge clk);
    if (get_tx(sel) !== 1'b1) ok = 1'b0;
  endtask

  task automatic run_dump(input bit sel, input logic [4:0][7:0] exp, input bit hold,
                          input string tag);
    logic [7:0] b;
    int         t, tp;
    bit         ok;
    tp = 0;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    if (!hold) set_start(sel, 1'b0);
    chk({tag, " busy after start"}, 32'(get_busy(sel)), 32'd1);
    chk({tag, " ce after start"}, 32'(get_ce(sel)), 32'd1);
    chk({tag, " done after start"}, 32'(get_done(sel)), 32'd0);
    chk({tag, " addr after start"}, 32'(get_addr(sel)), 32'd0);
    chk({tag, " checksum cleared"}, 32'(get_sum(sel)), 32'd0);
    for (int i = 0; i < 5; i++) begin
      rx_frame(sel, b, t, ok);
      chk($sformatf("%s frame%0d framing/timeout", tag, i), 32'(ok), 32'd1);
      if (!ok) return;
      chk($sformatf("%s byte%0d", tag, i), 32'(b), 32'(exp[i]));
      chk($sformatf("%s addr during frame%0d", tag, i), 32'(get_addr(sel)),
          (i < 4) ? 32'(i) : 32'd3);
      if (i > 0)
        chk($sformatf("%s spacing to frame%0d", tag, i), 32'(t - tp), (i == 4) ? 32'd40 : 32'd43);
      tp = t;
    end
    @(negedge clk);
    chk({tag, " busy in last stop cycle"}, 32'(get_busy(sel)), 32'd1);
    @(negedge clk);
    chk({tag, " done at end"}, 32'(get_done(sel)), 32'd1);
    chk({tag, " busy at end"}, 32'(get_busy(sel)), 32'd0);
    chk({tag, " ce at end"}, 32'(get_ce(sel)), 32'd0);
    chk({tag, " addr holds max"}, 32'(get_addr(sel)), 32'd3);
    chk({tag, " checksum output"}, 32'(get_sum(sel)), 32'(exp[4]));
  endtask

  task automatic load_rom(input vec_t v);
    rom8 = v.rom;
    for (int i = 0; i < 4; i++) rom4[i] = v.rom[i][3:0];
  endtask

  initial begin
    logic [7:0] b;
    int         t, idle_bad;
    bit         ok;

    vecs[0] = '{rom: {8'hF0, 8'h33, 8'h22, 8'h11},
                exp: {8'h56, 8'hF0, 8'h33, 8'h22, 8'h11}, narrow: 1'b0, name: "basic"};
    vecs[1] = '{rom: {8'h01, 8'h0F, 8'h05, 8'h0A},
                exp: {8'h1F, 8'h01, 8'h0F, 8'h05, 8'h0A}, narrow: 1'b1, name: "narrow4"};
    vecs[2] = '{rom: {8'hFF, 8'hFF, 8'hFF, 8'hFF},
                exp: {8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, narrow: 1'b0, name: "overflow"};
    vecs[3] = '{rom: {8'h7E, 8'h01, 8'h80, 8'h00},
                exp: {8'hFF, 8'h7E, 8'h01, 8'h80, 8'h00}, narrow: 1'b0, name: "mixed"};
    load_rom(vecs[0]);

    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx8), 32'd1);
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset ce", 32'(ce8), 32'd0);
    chk("reset addr", 32'(addr8), 32'd0);
    chk("reset checksum", 32'(sum8), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle tx", 32'(tx8), 32'd1);
    chk("idle busy", 32'(busy8), 32'd0);

    for (int v = 0; v < 4; v++) begin
      load_rom(vecs[v]);
      run_dump(vecs[v].narrow, vecs[v].exp, 1'b0, vecs[v].name);
      repeat (3) @(negedge clk);
    end

    // Start pulse in the middle of a dump must not restart it.
    load_rom(vecs[0]);
    fork
      run_dump(1'b0, vecs[0].exp, 1'b0, "midstart");
      begin
        repeat (60) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
      end
    join

    // Start held high: one dump only.
    run_dump(1'b0, vecs[0].exp, 1'b1, "held");
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx8 !== 1'b1 || busy8 !== 1'b0) idle_bad++;
    end
    chk("held no second dump", 32'(idle_bad), 32'd0);
    chk("held done stays", 32'(done8), 32'd1);
    start8 = 1'b0;
    @(negedge clk);
    run_dump(1'b0, vecs[0].exp, 1'b0, "restart");

    // Reset in the middle of the third frame, during a zero data bit.
    load_rom(vecs[0]);
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    rx_frame(1'b0, b, t, ok);
    chk("rst frame0", ok ? 32'(b) : 32'hFFFF, 32'h11);
    rx_frame(1'b0, b, t, ok);
    chk("rst frame1", ok ? 32'(b) : 32'hFFFF, 32'h22);
    repeat (17) @(negedge clk);
    chk("rst pre tx low", 32'(tx8), 32'd0);
    chk("rst pre addr", 32'(addr8), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst async tx", 32'(tx8), 32'd1);
    chk("rst async busy", 32'(busy8), 32'd0);
    chk("rst async done", 32'(done8), 32'd0);
    chk("rst async ce", 32'(ce8), 32'd0);
    chk("rst async addr", 32'(addr8), 32'd0);
    chk("rst async checksum", 32'(sum8), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst no resume", 32'(busy8), 32'd0);
    run_dump(1'b0, vecs[0].exp, 1'b0, "afterrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
